// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter between four byte sources. This block grants
// one requester at a time in round-robin order and registers that
// requester's byte onto tx_data. It then pulses tx_start and ack together for
// one cycle and follows the transmitter's tx_busy flag through the frame. An
// owner that keeps its request up may send up to MAX_BURST bytes
// back-to-back before the grant rotates. If tx_busy never rises after a
// start, the frame is abandoned after BUSY_TIMEOUT cycles and err pulses.
//
// Handshake: req[i] is a level held while requester i has a byte on
// req_data[8i+7:8i]. ack[i] pulses for one cycle when that byte has been
// taken. From the next cycle on, the requester shows its next byte or drops
// req[i]. The byte is sampled only on the cycle that leads into SEND.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   en         allows new grants from IDLE; has no effect on a grant in progress
//   req[3:0]   per-requester request level
//   req_data   four packed bytes, requester i on [8i+7:8i]
//   ack[3:0]   one-cycle "byte taken" pulse to the owner
//   grant[3:0] one-hot owner of the transmitter, zero when idle
//   tx_data    byte to the transmitter, stable from tx_start to end of frame
//   tx_start   one-cycle start strobe to the transmitter
//   tx_busy    transmitter frame in progress
//   err        one-cycle pulse when tx_busy fails to rise in time
//   state_dbg  current FSM state (IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3)

module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [7:0] TIMEOUT_V  = 8'(BUSY_TIMEOUT);

    // Registered state
    state_t      state;
    logic [1:0]  cur;
    logic [1:0]  last;
    logic [3:0]  burst_cnt;
    logic [7:0]  to_cnt;

    // Next-state values
    state_t      state_n;
    logic [1:0]  cur_n;
    logic [1:0]  last_n;
    logic [3:0]  burst_cnt_n;
    logic [7:0]  to_cnt_n;
    logic [3:0]  grant_n;
    logic [3:0]  ack_n;
    logic [7:0]  tx_data_n;
    logic        tx_start_n;
    logic        err_n;

    // Round-robin pick
    logic [1:0]  sel;
    logic [1:0]  cand;
    logic        found;
    logic [7:0]  to_inc;

    assign state_dbg = state;
    assign to_inc    = to_cnt + 8'd1;

    // Search last+1, last+2, last+3, last (mod 4). The fourth candidate
    // wraps back to the previous owner, so it can win only if nobody else is
    // asking.
    always_comb begin
        sel   = last;
        cand  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic. tx_start, ack and err are
    // pulses: they default low and are raised only on the transition that
    // produces them, so each one lasts exactly one cycle.
    always_comb begin
        state_n     = state;
        cur_n       = cur;
        last_n      = last;
        burst_cnt_n = burst_cnt;
        to_cnt_n    = to_cnt;
        grant_n     = grant;
        tx_data_n   = tx_data;
        ack_n       = 4'b0000;
        tx_start_n  = 1'b0;
        err_n       = 1'b0;

        unique case (state)
            IDLE: begin
                if (en && found) begin
                    grant_n     = 4'b0001 << sel;
                    cur_n       = sel;
                    tx_data_n   = req_data[{sel, 3'b000} +: 8];
                    burst_cnt_n = 4'd0;
                    tx_start_n  = 1'b1;
                    ack_n       = 4'b0001 << sel;
                    state_n     = SEND;
                end
            end

            SEND: begin
                // tx_start/ack are high during this cycle.
                to_cnt_n = 8'd0;
                state_n  = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (to_inc == TIMEOUT_V) begin
                    // Transmitter never acknowledged the start: abandon the
                    // grant and let the next requester in line have a turn.
                    err_n    = 1'b1;
                    last_n   = cur;
                    grant_n  = 4'b0000;
                    to_cnt_n = 8'd0;
                    state_n  = IDLE;
                end else begin
                    to_cnt_n = to_inc;
                end
            end

            WAIT_DONE: begin
                if (!tx_busy) begin
                    // en does not affect a burst continuation, only new grants.
                    if (req[cur] && (burst_cnt < BURST_LAST)) begin
                        tx_data_n   = req_data[{cur, 3'b000} +: 8];
                        burst_cnt_n = burst_cnt + 4'd1;
                        tx_start_n  = 1'b1;
                        ack_n       = 4'b0001 << cur;
                        state_n     = SEND;
                    end else begin
                        last_n  = cur;
                        grant_n = 4'b0000;
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= 2'd0;
            last      <= 2'd3;   // requester 0 is searched first after reset
            burst_cnt <= 4'd0;
            to_cnt    <= 8'd0;
            grant     <= 4'b0000;
            ack       <= 4'b0000;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            last      <= last_n;
            burst_cnt <= burst_cnt_n;
            to_cnt    <= to_cnt_n;
            grant     <= grant_n;
            ack       <= ack_n;
            tx_data   <= tx_data_n;
            tx_start  <= tx_start_n;
            err       <= err_n;
        end
    end

    // Structural properties of the outputs.
    a_start_single : assert property (@(posedge clk) disable iff (rst)
        tx_start |=> !tx_start);
    a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));
    a_err_clears   : assert property (@(posedge clk) disable iff (rst)
        err |-> (grant == 4'b0000));
    a_ack_is_start : assert property (@(posedge clk) disable iff (rst)
        (ack != 4'b0000) |-> (tx_start && (ack == grant)));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: transmitter model, byte/owner scoreboard,
// directed scenarios for arbitration, burst, timeout, enable and reset.

module tb_uart_tx_arbiter;

    localparam int MAX_BURST    = 4;
    localparam int BUSY_TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        err;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .MAX_BURST    (MAX_BURST),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // ---------------- transmitter model ----------------
    // Busy rises two cycles after the start cycle and stays high for 10 cycles.
    // With model_on low the transmitter never responds.
    logic model_on = 1'b1;
    int   phase = 0;

    always @(negedge clk) begin
        if (rst) begin
            phase   = 0;
            tx_busy = 1'b0;
        end else begin
            if (tx_start)
                phase = 1;
            else if (phase > 0)
                phase = phase + 1;
            tx_busy = model_on && (phase >= 3) && (phase <= 12);
            if (phase > 12)
                phase = 0;
        end
    end

    // ---------------- scoreboard ----------------
    // Entry = {owner[1:0], byte[7:0]}
    logic [9:0] exp_q[$];
    int   cyc = 0;
    int   last_start = 0;
    int   start_cnt = 0;
    int   err_cnt = 0;
    logic prev_start = 1'b0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            cyc++;
            if (tx_start) begin
                start_cnt++;
                last_start = cyc;
                check("start_back_to_back", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_start", 32'(tx_start), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e[7:0]));
                    check("grant_at_start", 32'(grant), 32'(oh(e[9:8])));
                    check("ack_at_start", 32'(ack), 32'(oh(e[9:8])));
                end
            end else if (ack != 4'b0000) begin
                check("ack_without_start", 32'(ack), 32'd0);
            end
            if (err) begin
                err_cnt++;
                check("err_latency", 32'(cyc - last_start), 32'(BUSY_TIMEOUT + 1));
                check("err_grant_clear", 32'(grant), 32'd0);
                check("err_single_cycle", 32'(prev_err), 32'd0);
            end
            prev_start = tx_start;
            prev_err   = err;
        end else begin
            prev_start = 1'b0;
            prev_err   = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        req = 4'b0000;
        en  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic push_n(input logic [1:0] owner, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({owner, b});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        int e0;
        int k;

        // 1) reset values and single byte from requester 0
        req_data = 32'h0000_0055;
        reset_dut();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        push_n(2'd0, 8'h55, 1);
        req = 4'b0001;
        @(negedge clk);
        #1;
        check("arb_latency_start", 32'(tx_start), 32'd1);
        check("arb_latency_ack", 32'(ack), 32'b0001);
        req = 4'b0000;
        idle_cycles(12);
        check("grant_held_to_frame_end", 32'(grant), 32'b0001);
        idle_cycles(1);
        check("grant_released", 32'(grant), 32'd0);
        wait_drain(10);

        // 2) all four requesting: order 0,1,2,3,0 with full bursts
        req_data = 32'hA3A2_A1A0;
        reset_dut();
        for (int r = 0; r < 5; r++)
            push_n(2'(r), 8'hA0 + 8'(r % 4), MAX_BURST);
        req = 4'b1111;
        wait_drain(1500);
        req = 4'b0000;
        idle_cycles(20);
        check("rr_idle_after", 32'(grant), 32'd0);

        // 3) requester 0 leaves after one byte; requester 2 gets a full burst
        reset_dut();
        push_n(2'd0, 8'hA0, 1);
        push_n(2'd2, 8'hA2, MAX_BURST);
        req = 4'b0101;
        k = 0;
        while (k < 20 && !ack[0]) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("wait_ack0", 32'(ack[0]), 32'd1);
        req[0] = 1'b0;
        wait_drain(300);
        req = 4'b0000;
        idle_cycles(20);

        // 4) transmitter never goes busy: timeout, then rotation to next
        model_on = 1'b0;
        reset_dut();
        e0 = err_cnt;
        push_n(2'd0, 8'hA0, 1);
        push_n(2'd1, 8'hA1, 1);
        req = 4'b0011;
        wait_drain(100);
        req = 4'b0000;
        idle_cycles(40);
        check("timeout_err_count", 32'(err_cnt - e0), 32'd2);
        check("timeout_idle_grant", 32'(grant), 32'd0);
        model_on = 1'b1;

        // 5) en gating: blocked while low, granted the cycle after it rises,
        //    burst survives en falling, no new grant afterwards
        en  = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        s0  = start_cnt;
        req = 4'b0010;
        idle_cycles(10);
        check("en_low_no_start", 32'(start_cnt - s0), 32'd0);
        push_n(2'd1, 8'hA1, MAX_BURST);
        en = 1'b1;
        @(negedge clk);
        #1;
        check("en_rise_start", 32'(tx_start), 32'd1);
        en = 1'b0;
        wait_drain(300);
        idle_cycles(30);
        check("en_low_after_burst", 32'(grant), 32'd0);
        check("en_burst_len", 32'(start_cnt - s0), 32'(MAX_BURST));
        req = 4'b0000;
        en  = 1'b1;

        // 6) reset in WAIT_DONE, then requesters 3 and 0 together
        reset_dut();
        push_n(2'd0, 8'hA0, 1);
        req = 4'b0001;
        wait_drain(10);
        k = 0;
        while (k < 20 && state_dbg != 2'd3) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("reach_wait_done", 32'(state_dbg), 32'd3);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_tx_data", 32'(tx_data), 32'd0);
        check("async_rst_tx_start", 32'(tx_start), 32'd0);
        check("async_rst_ack", 32'(ack), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        push_n(2'd0, 8'hA0, 1);
        req = 4'b1001;
        idle_cycles(2);
        rst = 1'b0;
        wait_drain(10);
        req = 4'b1000;
        push_n(2'd3, 8'hA3, MAX_BURST);
        wait_drain(300);
        req = 4'b0000;
        idle_cycles(20);
        check("final_idle_grant", 32'(grant), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between four byte sources. It grants one requester at a time, hands its byte to the transmitter with a one-cycle start strobe, and tracks the transmitter's busy flag through each frame. A granted requester may keep the transmitter for a bounded burst of bytes before the grant rotates. Sits between the protocol/reporting logic and the UART TX datapath, in the same clock domain as the UART.

## Interface
- `MAX_BURST`, default 4: maximum consecutive bytes per grant (1..15).
- `BUSY_TIMEOUT`, default 16: cycles allowed for `tx_busy` to rise after `tx_start` (2..255).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  high allows new grants; low blocks new grants only.
- `req`  in  4  per-requester request, level; held high while the requester has a byte.
- `req_data`  in  32  byte of requester i on bits [8i+7:8i].
- `ack`  out  4  one-cycle pulse: byte of requester i has been taken; the requester presents its next byte or drops `req` from the following cycle.
- `grant`  out  4  one-hot owner of the transmitter; zero when idle.
- `tx_data`  out  8  byte to the transmitter; stable from `tx_start` until the frame ends.
- `tx_start`  out  1  one-cycle start strobe to the transmitter.
- `tx_busy`  in  1  transmitter frame in progress.
- `err`  out  1  one-cycle pulse on busy timeout.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if `en` and `req` != 0, select the first set bit searching `last+1`, `last+2`, … mod 4. Then:
  - `grant` <= one-hot(sel); `cur` <= sel; `tx_data` <= byte sel; `burst_cnt` <= 0; go to SEND.
- SEND, one cycle: `tx_start`=1 and `ack[cur]`=1, both registered. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: wait for `tx_busy`=1, then go to WAIT_DONE.
  - The timeout counter increments each cycle. If it reaches `BUSY_TIMEOUT` with `tx_busy` still low: pulse `err`, set `last` <= `cur`, clear `grant`, go to IDLE.
- WAIT_DONE: wait for `tx_busy`=0, then:
  - If `req[cur]` and `burst_cnt` < `MAX_BURST-1` (`en` ignored): `tx_data` <= byte cur, `burst_cnt`+1, go to SEND.
  - Otherwise: `last` <= `cur`, clear `grant`, go to IDLE.
- `req` of non-granted requesters is ignored until IDLE. `req_data` is sampled only on the IDLE→SEND or WAIT_DONE→SEND edge.
- `en` falling mid-transfer has no effect on the current frame or burst continuation decision… except that the next IDLE arbitration is blocked.
- Reset values: state IDLE; `grant`, `ack`, `tx_start`, `err`, `tx_data`, `burst_cnt`, timeout counter = 0; `last` = 3, so requester 0 has priority after reset.
- Reset asserted mid-frame: all outputs return to reset values immediately. The transmitter's in-flight frame is not tracked; the next grant may start while `tx_busy` is still high and will pass through WAIT_BUSY immediately.

## Timing
- Arbitration latency: `req` high in IDLE at cycle N gives `grant` valid and `tx_data` valid at N+1, `tx_start`/`ack` high during N+1 only.
- `tx_start` is never high on two consecutive cycles. Minimum gap between starts = 3 cycles plus frame length.
- Burst re-issue: `tx_busy` seen low at cycle M gives the next `tx_start` at M+1.
- Rotation to another requester: `tx_busy` low at M, IDLE at M+1, `tx_start` at M+2.
- `err` is high exactly one cycle, coincident with `grant` clearing.
- `burst_cnt` is 4 bits and never wraps (bounded by `MAX_BURST-1`).

## Test plan
- Reset, then `req`=0001, byte0=0x55, transmitter model asserts busy 2 cycles after start for 10 cycles:
  - `tx_start` and `ack`=0001 one cycle after `req`, `tx_data`=0x55, `grant`=0001 until busy falls.
- `req`=1111 held, `MAX_BURST`=4, bytes 0xA0..0xA3: grant order 0,1,2,3,0; each owner sends exactly 4 bytes before rotating; 4 `ack` pulses per grant.
- `req`=0101 with requester 0 dropping `req` after its first `ack`: one byte from 0, then grant to 2, which gets full burst.
- Transmitter model never raises busy, `BUSY_TIMEOUT`=16: `err` pulses 17 cycles after `tx_start`, `grant`=0, next arbitration begins at the following requester.
- `en`=0 with `req`=0010: no `tx_start`; raise `en` → `tx_start` the next cycle. Drop `en` during a burst → burst completes, then no new grant.
- Assert `rst` during WAIT_DONE: all outputs 0 asynchronously; after release, `req`=1000 and `req`=0001 together → requester 0 granted first.
